// File: rtl/fp32_unpack_pkg.sv
// ============================================================================
// Module : fp32Pkg
// Brief  : Shared FP32 widths, unpacked-operand types, class bit indices and
//          pipeline stage records for the FP32 unpacker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp32Pkg;

    localparam int EMSB  = 7;
    localparam int FMSB  = 22;
    localparam int CLS_W = 7;

    // Set to 1 to collapse the unpacker into pure combinational logic.
    localparam bit MIN_LATENCY = 1'b0;
    localparam int LATENCY     = MIN_LATENCY ? 0 : 3;

    typedef logic [31:0] FP32;

    typedef struct packed {
        logic              sign;
        logic [EMSB+2:0]   exp;
        logic [FMSB+1:0]   sig;
    } FP32U;

    // Bit positions inside the class vector {zero, dn, inf, nan, qnan, snan, neg}.
    typedef enum logic [2:0] {
        CLS_NEG  = 3'd0,
        CLS_SNAN = 3'd1,
        CLS_QNAN = 3'd2,
        CLS_NAN  = 3'd3,
        CLS_INF  = 3'd4,
        CLS_DN   = 3'd5,
        CLS_ZERO = 3'd6
    } FP32CLS;

    typedef struct packed {
        logic              vld;
        logic              sign;
        logic [EMSB:0]     exp;
        logic [FMSB:0]     frac;
        logic [4:0]        lz;
        logic [CLS_W-1:0]  cls;
    } fp32_s1_t;

    typedef struct packed {
        logic              vld;
        FP32U              u;
        logic [CLS_W-1:0]  cls;
    } fp32_s2_t;

    function automatic logic [CLS_W-1:0] fp32_classify(input FP32 a);
        logic             w_exp_zero;
        logic             w_exp_max;
        logic             w_frac_nz;
        logic [CLS_W-1:0] w_c;
        w_exp_zero      = ~|a[30:23];
        w_exp_max       = &a[30:23];
        w_frac_nz       = |a[FMSB:0];
        w_c             = '0;
        w_c[CLS_ZERO]   = w_exp_zero & ~w_frac_nz;
        w_c[CLS_DN]     = w_exp_zero &  w_frac_nz;
        w_c[CLS_INF]    = w_exp_max  & ~w_frac_nz;
        w_c[CLS_NAN]    = w_exp_max  &  w_frac_nz;
        w_c[CLS_QNAN]   = w_exp_max  &  w_frac_nz &  a[FMSB];
        w_c[CLS_SNAN]   = w_exp_max  &  w_frac_nz & ~a[FMSB];
        w_c[CLS_NEG]    = a[31];
        return w_c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_unpack_cntlz23.sv
// ============================================================================
// Module : cntlz23
// Brief  : Combinational leading-zero count of a 23-bit vector (23 when zero).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cntlz23 (
    input  logic [22:0] i_d,
    output logic [4:0]  o_cnt
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        o_cnt = 5'd23;
        for (int k = 0; k < 23; k++) begin
            if (i_d[k]) begin
                o_cnt = 5'(22 - k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp32_unpack.sv
// ============================================================================
// Module : fp32_unpack
// Brief  : 3-stage FP32 unpacker: sign, 10-bit signed biased exponent,
//          24-bit significand with explicit leading one, IEEE class flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp32_unpack
    import fp32Pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              vi,
    input  logic [31:0]       i,
    output logic              vo,
    output FP32U              o,
    output logic [CLS_W-1:0]  cls
);

    logic             w_pipe_adv;
    logic [4:0]       w_lz;
    fp32_s1_t         w_dec;
    fp32_s1_t         w_s1;
    fp32_s2_t         w_shf;
    fp32_s2_t         w_s3;
    logic [FMSB+1:0]  w_ext;
    logic [4:0]       w_shamt;

    assign w_pipe_adv = ce;

    cntlz23 u_cntlz23 (
        .i_d   (i[FMSB:0]),
        .o_cnt (w_lz)
    );

    always_comb begin
        w_dec      = '0;
        w_dec.vld  = vi;
        w_dec.sign = i[31];
        w_dec.exp  = i[30:23];
        w_dec.frac = i[FMSB:0];
        w_dec.lz   = w_lz;
        w_dec.cls  = fp32_classify(i);
    end

    // Denormals: shift past the leading zeros plus the bit that becomes the explicit one.
    assign w_ext   = {1'b0, w_s1.frac};
    assign w_shamt = w_s1.lz + 5'd1;

    always_comb begin
        w_shf        = '0;
        w_shf.vld    = w_s1.vld;
        w_shf.cls    = w_s1.cls;
        w_shf.u.sign = w_s1.sign;
        if (w_s1.cls[CLS_DN]) begin
            w_shf.u.sig = w_ext << w_shamt;
            w_shf.u.exp = 10'd0 - {5'd0, w_s1.lz};
        end else if (w_s1.cls[CLS_ZERO]) begin
            w_shf.u.sig = '0;
            w_shf.u.exp = '0;
        end else begin
            w_shf.u.sig = {1'b1, w_s1.frac};
            w_shf.u.exp = {2'b00, w_s1.exp};
        end
    end

    generate
        if (MIN_LATENCY) begin : g_comb
            assign w_s1 = w_dec;
            assign w_s3 = w_shf;
        end else begin : g_pipe
            fp32_s1_t r_s1;
            fp32_s2_t r_s2;
            fp32_s2_t r_s3;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1 <= '0;
                    r_s2 <= '0;
                    r_s3 <= '0;
                end else if (w_pipe_adv) begin
                    r_s1 <= w_dec;
                    r_s2 <= w_shf;
                    r_s3 <= r_s2;
                end
            end

            assign w_s1 = r_s1;
            assign w_s3 = r_s3;
        end
    endgenerate

    assign vo  = w_s3.vld;
    assign o   = w_s3.u;
    assign cls = w_s3.cls;

endmodule

`default_nettype wire

// File: tb/tb_fp32_unpack.sv
// ============================================================================
// Module : tb_fp32_unpack
// Brief  : Scoreboard bench for fp32_unpack: directed vectors, stall, reset,
//          and random operands against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp32_unpack;
    import fp32Pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        vi;
    logic [31:0] din;
    logic        vo;
    FP32U        o;
    logic [6:0]  cls;

    always #5 clk = ~clk;

    fp32_unpack dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .vi  (vi),
        .i   (din),
        .vo  (vo),
        .o   (o),
        .cls (cls)
    );

    typedef struct {
        logic [31:0] din;
        FP32U        u;
        logic [6:0]  c;
        int          cap;
    } sb_t;

    sb_t         q[$];
    int          checks = 0;
    int          fails  = 0;
    int          en_cnt = 0;
    logic        m_en;
    logic        m_rs;
    logic [42:0] prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic FP32U mk(input logic s, input logic [9:0] e, input logic [23:0] g);
        FP32U r;
        r.sign = s;
        r.exp  = e;
        r.sig  = g;
        return r;
    endfunction

    // Reference: normalise denormals by shifting until bit 23 is set, exponent starts at 1.
    function automatic sb_t model(input logic [31:0] x);
        sb_t         r;
        logic [7:0]  e;
        logic [22:0] f;
        logic [23:0] m;
        int          ex;
        e = x[30:23];
        f = x[22:0];
        r.din = x;
        r.cap = 0;
        r.c = 7'd0;
        r.c[0] = x[31];
        r.u.sign = x[31];
        if (e == 8'hFF) begin
            r.u.exp = 10'd255;
            r.u.sig = {1'b1, f};
            if (f == 23'd0) r.c[4] = 1'b1;
            else begin
                r.c[3] = 1'b1;
                r.c[2] = f[22];
                r.c[1] = ~f[22];
            end
        end else if (e == 8'd0) begin
            if (f == 23'd0) begin
                r.c[6] = 1'b1;
                r.u.exp = 10'd0;
                r.u.sig = 24'd0;
            end else begin
                r.c[5] = 1'b1;
                m = {1'b0, f};
                ex = 1;
                while (!m[23]) begin
                    m = m << 1;
                    ex--;
                end
                r.u.sig = m;
                r.u.exp = 10'(ex);
            end
        end else begin
            r.u.exp = {2'b00, e};
            r.u.sig = {1'b1, f};
        end
        return r;
    endfunction

    task automatic step(input logic c, input logic v, input logic [31:0] d,
                        input FP32U eu, input logic [6:0] ec);
        sb_t e;
        @(negedge clk);
        ce  = c;
        vi  = v;
        din = d;
        @(posedge clk);
        if (c && v && !rst) begin
            e.din = d;
            e.u   = eu;
            e.c   = ec;
            e.cap = en_cnt + 1;
            q.push_back(e);
        end
    endtask

    task automatic step_model(input logic c, input logic v, input logic [31:0] d);
        sb_t m;
        m = model(d);
        step(c, v, d, m.u, m.c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ce  = 1'b0;
        vi  = 1'b1;
        din = 32'h3F800000;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        vi  = 1'b0;
    endtask

    // Monitor: one pop per enabled edge that presents vo; held outputs must not change.
    always @(posedge clk) begin
        sb_t         e;
        logic [7:0]  ie;
        logic [23:0] mm;
        int          sh;
        m_en = ce && !rst;
        m_rs = rst;
        #1;
        if (m_rs) begin
            check("rst_vo", 64'(vo), 64'd0);
            check("rst_o", 64'(o), 64'd0);
            check("rst_cls", 64'(cls), 64'd0);
        end else if (!m_en) begin
            check("stall_hold", 64'({vo, o, cls}), 64'(prev));
        end else begin
            en_cnt++;
            if (vo) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_vo: got vo=1 o=%h required no output", o);
                end else begin
                    e = q.pop_front();
                    check("out_o", 64'(o), 64'(e.u));
                    check("out_cls", 64'(cls), 64'(e.c));
                    check("latency", 64'(en_cnt), 64'(e.cap + 2));
                    ie = e.din[30:23];
                    if (ie != 8'hFF && e.din[30:0] != 31'd0) begin
                        mm = (ie == 8'd0) ? {1'b0, e.din[22:0]} : {1'b1, e.din[22:0]};
                        sh = ((ie == 8'd0) ? 1 : int'(ie)) - int'($signed(o.exp));
                        if (sh < 0 || sh > 30) check("identity_shift", 64'(sh), 64'd0);
                        else check("identity", 64'(o.sig), 64'(mm) << sh);
                    end
                end
            end else if (q.size() != 0 && en_cnt > q[0].cap + 2) begin
                checks++;
                fails++;
                $display("FAIL missing_vo: got vo=0 required output for %h", q[0].din);
                void'(q.pop_front());
            end
        end
        prev = {vo, o, cls};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          r;
        rst = 1'b1;
        ce  = 1'b0;
        vi  = 1'b0;
        din = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        step(1, 1, 32'h3F800000, mk(0, 10'd127,  24'h800000), 7'b0000000);
        step(1, 0, 32'h12345678, mk(0, 10'd0,    24'h0),      7'b0000000);
        step(1, 1, 32'h00000001, mk(0, 10'h3EA,  24'h800000), 7'b0100000);
        step(1, 1, 32'h00400000, mk(0, 10'd0,    24'h800000), 7'b0100000);
        step(1, 1, 32'h80000000, mk(1, 10'd0,    24'h000000), 7'b1000001);
        step(1, 1, 32'hFF800000, mk(1, 10'd255,  24'h800000), 7'b0010001);
        step(1, 1, 32'h7FC00001, mk(0, 10'd255,  24'hC00001), 7'b0001100);
        step(1, 1, 32'h7F800001, mk(0, 10'd255,  24'h800001), 7'b0001010);
        step(1, 1, 32'hC0490FDB, mk(1, 10'd128,  24'hC90FDB), 7'b0000001);
        step(1, 1, 32'h00000000, mk(0, 10'd0,    24'h000000), 7'b1000000);
        step(1, 1, 32'h007FFFFF, mk(0, 10'd0,    24'hFFFFFE), 7'b0100000);
        step(1, 1, 32'h7F7FFFFF, mk(0, 10'd254,  24'hFFFFFF), 7'b0000000);
        step(1, 1, 32'h00000002, mk(0, 10'h3EB,  24'h800000), 7'b0100000);

        // Back-to-back with a two-cycle stall in the middle.
        step(1, 1, 32'h40000000, mk(0, 10'd128,  24'h800000), 7'b0000000);
        step(1, 1, 32'h3F000000, mk(0, 10'd126,  24'h800000), 7'b0000000);
        step(1, 1, 32'hBF800000, mk(1, 10'd127,  24'h800000), 7'b0000001);
        step(0, 1, 32'h7FFFFFFF, mk(0, 10'd255,  24'hFFFFFF), 7'b0001100);
        step(0, 1, 32'h7FFFFFFF, mk(0, 10'd255,  24'hFFFFFF), 7'b0001100);
        step(1, 1, 32'h80000001, mk(1, 10'h3EA,  24'h800000), 7'b0100001);
        step(1, 1, 32'h00800000, mk(0, 10'd1,    24'h800000), 7'b0000000);
        repeat (5) step_model(1, 0, 32'd0);

        // Reset with three operands in flight.
        step(1, 1, 32'h3F800000, mk(0, 10'd127,  24'h800000), 7'b0000000);
        step(1, 1, 32'h40400000, mk(0, 10'd128,  24'hC00000), 7'b0000000);
        step(1, 1, 32'h40800000, mk(0, 10'd129,  24'h800000), 7'b0000000);
        do_reset();
        repeat (6) step_model(1, 0, 32'd0);

        for (int n = 0; n < 10000; n++) begin
            d = $urandom;
            r = int'($urandom_range(0, 7));
            if (r == 0) d[30:23] = 8'h00;
            if (r == 1) d[30:23] = 8'hFF;
            if (r == 2) d[22:0]  = 23'd0;
            if (r == 3) d[22:0]  = 23'd1 << $urandom_range(0, 22);
            step_model(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), d);
        end

        repeat (8) step_model(1, 0, 32'd0);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp32_unpack.md
# fp32_unpack

Pipelined IEEE-754 binary32 unpacker that produces operand fields for the arithmetic units, which later feed the rounding stage. It splits an FP32 operand into sign, a 10-bit signed biased exponent and a 24-bit significand with an explicit leading one. Denormals are pre-normalised using a leading-zero count, so downstream units never handle a hidden bit. It also emits IEEE class flags. Latency is fixed at 3 clocks with one operand accepted per clock, matching the latency of the rounding unit at the other end of the datapath.

## Interface
Parameters:
- none. Widths come from `fp32Pkg` (`EMSB`=7, `FMSB`=22).

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; synchronous, active-high; overrides `ce`
- `ce`  in  1  clock enable; 0 freezes every pipeline register, including valid
- `vi`  in  1  input valid
- `i`  in  32  `FP32` operand
- `vo`  out  1  output valid
- `o`  out  `FP32U`  unpacked result: `sign`, `exp[9:0]` (signed, biased), `sig[23:0]`
- `cls`  out  7  {`zero`, `dn`, `inf`, `nan`, `qnan`, `snan`, `neg`}

## Operation
- **Normal**, exp in 1..254:
  - `exp` = {2'b00, exp}.
  - `sig` = {1, frac}.
- **Denormal**, exp=0 and frac≠0:
  - lz = leading zeros of the 23-bit frac (0..22).
  - `sig` = frac << (lz+1), truncated to 24 bits, so `sig[23]`=1.
  - `exp` = -lz as 10-bit two's complement.
  - `dn`=1.
- **Zero**, exp=0 and frac=0: `exp`=0, `sig`=0, `zero`=1.
- **Inf**, exp=255 and frac=0: `exp`=10'd255, `sig`=24'h800000, `inf`=1.
- **NaN**, exp=255 and frac≠0:
  - `exp`=10'd255, `sig`={1, frac}; the payload is preserved.
  - `nan`=1.
  - `qnan`=frac[22], `snan`=~frac[22].
- **Sign:** `sign` passes through for all classes; `neg`=`sign`.
- **Flag exclusivity:** exactly one of `zero`/`dn`/`inf`/`nan` is set for non-normal inputs; all four are 0 for normal inputs.
- **Exponent width:** the exponent range is -22..255, so 10 bits are sufficient and no overflow is possible.

## Timing
- **Latency:** `o`, `cls` and `vo` appear exactly 3 enabled clocks after `vi`/`i` are sampled with `ce`=1.
- **Throughput:** 1 per clock. No backpressure; a consumer stalls the unit by deasserting `ce`.
- **Pipeline stages:**
  - Stage 1 registers sign/exp/frac, the class flags and the lz count.
  - Stage 2 performs the left shift and the exponent negation.
  - Stage 3 registers the outputs.
- **Reset:** `rst`=1 on a clock edge clears every stage.
  - `vo`=0, `o`=0, `cls`=0 on the following cycle.
  - Operands in flight are discarded; there is no partial output.
- **`ce`=0:** all stages hold; `vo`/`o` stay stable and outputs are not duplicated.
- **`vi`=0:** data still advances. `o` is don't-care but deterministic, and `vo`=0 for that slot.
- **`vi` with `ce`=0:** the operand is not captured.

## Structure
- Add `FP32U` (packed struct: `sign`, `logic [EMSB+2:0] exp`, `logic [FMSB+1:0] sig`) to `fp32Pkg`.
- Add an `FP32CLS` bit-index enum to `fp32Pkg`.
- One sub-module: `cntlz23`, a combinational leading-zero count of 23 bits giving a 5-bit result (23 for an all-zero input). It is used in stage 1.
- The shifter and class logic are inline.
- Pipeline registers use the same `PIPE_ADV` / `MIN_LATENCY` convention as the other FP units. Under `MIN_LATENCY` the unit is fully combinational and `vo`=`vi`.

## Test plan
- **Normal:** `i`=32'h3F800000 with `vi`=1 -> 3 clocks later `vo`=1, sign 0, `exp`=10'd127, `sig`=24'h800000, `cls`=0.
- **Denormals:**
  - 32'h00000001 -> `exp`=10'h3EA (-22), `sig`=24'h800000, `dn`=1.
  - 32'h00400000 -> `exp`=0, `sig`=24'h800000, `dn`=1.
- **Specials:**
  - 32'h80000000 -> `zero`=1, `neg`=1, `exp`=0, `sig`=0.
  - 32'hFF800000 -> `inf`=1, `neg`=1, `exp`=255.
  - 32'h7FC00001 -> `nan`=1, `qnan`=1, `sig`=24'hC00001.
  - 32'h7F800001 -> `snan`=1.
- **Throughput and stall:**
  - Stimulus: 5 back-to-back operands, then `ce`=0 for 2 clocks in mid-stream.
  - Required: results arrive in order, one per enabled clock, with no loss or duplication, and outputs are held during the stall.
- **Reset mid-flight:**
  - Stimulus: assert `rst` with 3 valid operands in the pipe.
  - Required: `vo`=0 and `o`=0 from the next cycle, and no stale result emerges after `rst` is released.
- **Randomised:** 10k random bit patterns compared against a reference model. The check includes the value identity: sig·2^(exp-127-23) equals the input value for finite inputs.
